// File: rtl/tiny_npu_pkg.sv
// tiny_npu shared package: FSM states, default widths, result formatting.
// Optional feature macro: TINY_NPU_RELU_EN (handled in tiny_npu_lane).
package tiny_npu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        MAC,
        DRAIN
    } npu_state_t;

    localparam int NPU_NBITS = 8;
    localparam int NPU_DEPTH = 8;
    localparam int NPU_PBITS = 2 * NPU_NBITS;
    localparam int NPU_ABITS = NPU_PBITS + $clog2(NPU_DEPTH);

    // Arithmetic shift right by dbits, then clamp to the signed nbits range.
    function automatic logic signed [31:0] sat_shift(
        input logic signed [63:0] acc,
        input int                 nbits,
        input int                 dbits
    );
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        s  = acc >>> dbits;
        mx = (64'sd1 <<< (nbits - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (nbits - 1));
        if (s > mx) begin
            s = mx;
        end else if (s < mn) begin
            s = mn;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/tiny_npu_fifo.sv
// tiny_npu FIFO: single-clock, fall-through read, simultaneous push/pop.
// Used for the shared x FIFO and every per-lane weight FIFO.
module tiny_npu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_din,
    input  logic                   i_pop,
    output logic [W-1:0]           o_dout,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PB = $clog2(DEPTH);
    localparam int CB = PB + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PB-1:0] r_wr;
    logic [PB-1:0] r_rd;
    logic [CB-1:0] r_cnt;

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointers and occupancy, explicitly wrapped so DEPTH need not be 2^n.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wr <= (r_wr == PB'(DEPTH - 1)) ? '0 : r_wr + PB'(1);
            end
            if (i_pop) begin
                r_rd <= (r_rd == PB'(DEPTH - 1)) ? '0 : r_rd + PB'(1);
            end
            if (i_push && !i_pop) begin
                r_cnt <= r_cnt + CB'(1);
            end else if (!i_push && i_pop) begin
                r_cnt <= r_cnt - CB'(1);
            end
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_full  = (r_cnt == CB'(DEPTH));
    assign o_count = r_cnt;

endmodule

// File: rtl/tiny_npu_lane.sv
// tiny_npu MAC lane: signed multiply-accumulate plus result formatting.
// TINY_NPU_RELU_EN clamps negative formatted results to zero.
module tiny_npu_lane
    import tiny_npu_pkg::*;
#(
    parameter int NBITS = NPU_NBITS,
    parameter int DEPTH = NPU_DEPTH,
    parameter int DBITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [NBITS-1:0] i_x,
    input  logic signed [NBITS-1:0] i_w,
    output logic signed [NBITS-1:0] o_res
);
    localparam int PB = 2 * NBITS;
    localparam int AB = PB + $clog2(DEPTH);

    logic signed [PB-1:0]    w_prod;
    logic signed [AB-1:0]    w_acc_nxt;
    logic signed [AB-1:0]    r_acc;
    logic signed [NBITS-1:0] w_res;

    assign w_prod    = PB'(i_x) * PB'(i_w);
    assign w_acc_nxt = i_en ? r_acc + AB'(w_prod) : r_acc;

    // Accumulator: cleared at job start, grows by one product per MAC step.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    // Formatting looks at the post-step value so the last product is seen.
    assign w_res = NBITS'(sat_shift(64'(w_acc_nxt), NBITS, DBITS));

`ifdef TINY_NPU_RELU_EN
    assign o_res = w_res[NBITS-1] ? '0 : w_res;
`else
    assign o_res = w_res;
`endif

endmodule

// File: rtl/tiny_npu_tile.sv
// tiny_npu_tile: LANES MAC lanes fed by a broadcast x FIFO and per-lane
// weight FIFOs. Optional macro TINY_NPU_RELU_EN enables ReLU on results.
module tiny_npu_tile
    import tiny_npu_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 8,
    parameter int NBITS = 8,
    parameter int DBITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     x_in_val,
    output logic                     x_in_rdy,
    input  logic [NBITS-1:0]         x_in,
    input  logic                     w_in_val,
    output logic                     w_in_rdy,
    input  logic [NBITS-1:0]         w_in,
    input  logic [$clog2(LANES)-1:0] w_in_sel,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     feedback,
    output logic                     busy,
    output logic                     z_out_val,
    input  logic                     z_out_rdy,
    output logic [NBITS-1:0]         z_out,
    output logic                     done
);
    localparam int LB = $clog2(LANES);
    localparam int CB = $clog2(DEPTH) + 1;

    npu_state_t r_state;
    npu_state_t w_nxt;

    logic [CB-1:0]    r_len;
    logic             r_fb;
    logic [CB-1:0]    r_step;
    logic [LB-1:0]    r_lane;
    logic [NBITS-1:0] r_z;
    logic             r_zval;

    logic             w_mac;
    logic             w_clr;
    logic             w_load;
    logic             w_xfer;
    logic             w_last;
    logic             w_w_ok;
    logic [CB-1:0]    w_len_c;

    logic             w_x_push;
    logic [NBITS-1:0] w_x_din;
    logic [NBITS-1:0] w_x_dout;
    logic             w_x_full;
    logic [CB-1:0]    w_x_cnt;
    logic             w_fb_push;

    logic [NBITS-1:0] w_wdout [LANES];
    logic [CB-1:0]    w_wcnt  [LANES];
    logic [NBITS-1:0] w_res   [LANES];
    logic [LANES-1:0] w_wfull;
    logic [LANES-1:0] w_wpush;

    assign w_len_c   = (len > CB'(DEPTH)) ? CB'(DEPTH) : len;
    assign w_last    = (r_lane == LB'(LANES - 1));
    assign w_fb_push = (r_state == DRAIN) && r_fb && !w_x_full;
    assign w_xfer    = (r_state == DRAIN) &&
                       (r_fb ? !w_x_full : (r_zval && z_out_rdy));

    assign x_in_rdy = !w_x_full && !((r_state == DRAIN) && r_fb);
    assign w_in_rdy = !w_wfull[w_in_sel];
    assign w_x_push = (x_in_val && x_in_rdy) || w_fb_push;
    assign w_x_din  = w_fb_push ? r_z : x_in;

    assign busy      = (r_state != IDLE);
    assign done      = w_xfer && w_last;
    assign z_out_val = r_zval;
    assign z_out     = r_z;

    tiny_npu_fifo #(.W(NBITS), .DEPTH(DEPTH)) u_xfifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_x_push),
        .i_din   (w_x_din),
        .i_pop   (w_mac),
        .o_dout  (w_x_dout),
        .o_full  (w_x_full),
        .o_count (w_x_cnt)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_wpush[k] = w_in_val && w_in_rdy && (w_in_sel == LB'(k));

        tiny_npu_fifo #(.W(NBITS), .DEPTH(DEPTH)) u_wfifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_wpush[k]),
            .i_din   (w_in),
            .i_pop   (w_mac),
            .o_dout  (w_wdout[k]),
            .o_full  (w_wfull[k]),
            .o_count (w_wcnt[k])
        );

        tiny_npu_lane #(.NBITS(NBITS), .DEPTH(DEPTH), .DBITS(DBITS)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .i_clr (w_clr),
            .i_en  (w_mac),
            .i_x   (w_x_dout),
            .i_w   (w_wdout[k]),
            .o_res (w_res[k])
        );
    end

    // Every lane must hold at least len weights before MAC may start.
    always_comb begin
        w_w_ok = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (w_wcnt[k] < r_len) begin
                w_w_ok = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // FSM next state and phase strobes.
    always_comb begin
        w_nxt  = r_state;
        w_mac  = 1'b0;
        w_clr  = 1'b0;
        w_load = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_nxt = WAIT;
                    w_clr = 1'b1;
                end
            end
            WAIT: begin
                if (r_len == '0) begin
                    w_nxt  = DRAIN;
                    w_load = 1'b1;
                end else if (w_x_cnt >= r_len && w_w_ok) begin
                    w_nxt = MAC;
                end
            end
            MAC: begin
                w_mac = 1'b1;
                if (r_step == r_len - CB'(1)) begin
                    w_nxt  = DRAIN;
                    w_load = 1'b1;
                end
            end
            DRAIN: begin
                if (w_xfer && w_last) begin
                    w_nxt = IDLE;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Job parameters, MAC step count and the registered result port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len  <= '0;
            r_fb   <= 1'b0;
            r_step <= '0;
            r_lane <= '0;
            r_z    <= '0;
            r_zval <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_len <= w_len_c;
                r_fb  <= feedback;
            end
            r_step <= w_mac ? r_step + CB'(1) : '0;
            if (w_load) begin
                r_z    <= w_res[0];
                r_zval <= !r_fb;
                r_lane <= '0;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_zval <= 1'b0;
                end else begin
                    r_z <= w_res[r_lane + LB'(1)];
                end
                r_lane <= r_lane + LB'(1);
            end
        end
    end

endmodule

// File: tb/tb_tiny_npu_tile.sv
// tb_tiny_npu_tile: directed vectors with hand-computed results.
// Build with TINY_NPU_RELU_EN defined to expect ReLU-clamped results.
module tb_tiny_npu_tile;

    localparam int LANES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_in_val = 1'b0;
    logic       x_in_rdy;
    logic [7:0] x_in = '0;
    logic       w_in_val = 1'b0;
    logic       w_in_rdy;
    logic [7:0] w_in = '0;
    logic [1:0] w_in_sel = '0;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic       feedback = 1'b0;
    logic       busy;
    logic       z_out_val;
    logic       z_out_rdy = 1'b1;
    logic [7:0] z_out;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;
    int q[$];
    int ndone;
    int tfirst;
    int tdone;

    tiny_npu_tile #(.LANES(4), .DEPTH(8), .NBITS(8), .DBITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .x_in_val  (x_in_val),
        .x_in_rdy  (x_in_rdy),
        .x_in      (x_in),
        .w_in_val  (w_in_val),
        .w_in_rdy  (w_in_rdy),
        .w_in      (w_in),
        .w_in_sel  (w_in_sel),
        .start     (start),
        .len       (len),
        .feedback  (feedback),
        .busy      (busy),
        .z_out_val (z_out_val),
        .z_out_rdy (z_out_rdy),
        .z_out     (z_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rl(input int v);
`ifdef TINY_NPU_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic push_x(input int v);
        int n;
        n = 0;
        x_in = 8'(v);
        x_in_val = 1'b1;
        @(negedge clk);
        while (!x_in_rdy && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (!x_in_rdy) chk("x_push_to", 0, 1);
        @(posedge clk); #1;
        x_in_val = 1'b0;
    endtask

    task automatic push_w(input int lane, input int v);
        int n;
        n = 0;
        w_in_sel = 2'(lane);
        w_in = 8'(v);
        w_in_val = 1'b1;
        @(negedge clk);
        while (!w_in_rdy && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (!w_in_rdy) chk("w_push_to", 0, 1);
        @(posedge clk); #1;
        w_in_val = 1'b0;
    endtask

    task automatic start_job(input int l, input bit fb);
        start = 1'b1;
        len = 4'(l);
        feedback = fb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_drain(input int stall);
        int c;
        int stalled;
        int ok;
        logic [7:0] h;
        q.delete();
        ndone = 0;
        tfirst = -1;
        tdone = -1;
        c = 1;
        stalled = 0;
        ok = 1;
        z_out_rdy = 1'b1;
        while (q.size() < LANES && c < 100) begin
            @(negedge clk);
            if (z_out_val && tfirst < 0) tfirst = c;
            if (done) begin
                ndone++;
                tdone = c;
            end
            if (z_out_val && z_out_rdy) q.push_back(int'($signed(z_out)));
            @(posedge clk); #1;
            c++;
            if (stall > 0 && stalled == 0 && q.size() == 1) begin
                stalled = 1;
                z_out_rdy = 1'b0;
                @(negedge clk);
                h = z_out;
                for (int i = 0; i < stall; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!z_out_val || z_out != h || done) ok = 0;
                    @(posedge clk); #1;
                    c++;
                end
                z_out_rdy = 1'b1;
            end
        end
        if (q.size() < LANES) chk("drain_timeout", q.size(), LANES);
        if (stall > 0) begin
            chk("bp_stable", ok, 1);
            chk("bp_held_val", int'($signed(h)), 127);
        end
    endtask

    task automatic chk_res(input string tag, input int e0, input int e1,
                           input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("%s_l%0d", tag, i),
                (i < q.size()) ? q[i] : -999, e[i]);
        end
    endtask

    initial begin
        int nlow;
        int nval;
        int c;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zval", z_out_val, 0);
        chk("rst_z", z_out, 0);
        chk("rst_xrdy", x_in_rdy, 1);
        chk("rst_wrdy", w_in_rdy, 1);

        // Basic MAC, plus latency checks.
        for (int i = 0; i < 4; i++) push_x(16);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) push_w(k, 16 * (k + 1));
        start_job(4, 1'b0);
        chk("t1_busy", busy, 1);
        run_drain(0);
        chk_res("t1", 64, 127, 127, 127);
        chk("t1_ndone", ndone, 1);
        chk("t1_tfirst", tfirst, 6);
        chk("t1_tdone", tdone, 9);
        chk("t1_idle", busy, 0);

        // Negative and saturating results, len=1.
        push_x(-16);
        push_w(0, 16);
        push_w(1, -128);
        push_w(2, 127);
        push_w(3, 0);
        start_job(1, 1'b0);
        run_drain(0);
        chk_res("t2", rl(-16), 127, rl(-127), 0);

        // Backpressure mid-drain.
        for (int i = 0; i < 4; i++) push_x(16);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) push_w(k, 16 * (k + 1));
        start_job(4, 1'b0);
        run_drain(3);
        chk_res("t3", 64, 127, 127, 127);
        chk("t3_ndone", ndone, 1);

        // len=0 drains zeros without touching the FIFOs.
        start_job(0, 1'b0);
        run_drain(0);
        chk_res("t4", 0, 0, 0, 0);
        chk("t4_tfirst", tfirst, 2);
        chk("t4_tdone", tdone, 5);

        // Feedback job: identity weights, results land in the x FIFO.
        push_x(32);
        push_x(-16);
        push_x(48);
        push_x(0);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) push_w(k, (j == k) ? 16 : 0);
        start_job(4, 1'b1);
        nlow = 0;
        nval = 0;
        ndone = 0;
        c = 0;
        while (busy && c < 50) begin
            @(negedge clk);
            if (!x_in_rdy) nlow++;
            if (z_out_val) nval++;
            if (done) ndone++;
            @(posedge clk); #1;
            c++;
        end
        chk("fb_idle", busy, 0);
        chk("fb_xrdy_low", nlow, 4);
        chk("fb_zval", nval, 0);
        chk("fb_ndone", ndone, 1);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) push_w(k, (j == k) ? 16 : 0);
        start_job(4, 1'b0);
        run_drain(0);
        chk_res("fb2", 32, rl(-16), 48, 0);

        // WAIT stall until lane 2 gets its third weight.
        push_x(16);
        push_x(32);
        push_x(-16);
        for (int i = 0; i < 3; i++) begin
            push_w(0, 16);
            push_w(1, -16);
            push_w(3, 8);
        end
        push_w(2, 32);
        push_w(2, 32);
        start_job(3, 1'b0);
        nval = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (z_out_val || !busy) nval++;
            @(posedge clk); #1;
        end
        chk("ws_stalled", nval, 0);
        push_w(2, 32);
        run_drain(0);
        chk("ws_tfirst", tfirst, 5);
        chk_res("ws", 32, rl(-32), 64, 16);

        // Reset in the middle of MAC, then a fresh job.
        for (int i = 0; i < 4; i++) push_x(16);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) push_w(k, 16);
        start_job(4, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_zval", z_out_val, 0);
        chk("mr_xrdy", x_in_rdy, 1);
        push_x(32);
        for (int k = 0; k < 4; k++) push_w(k, 16 * k);
        start_job(1, 1'b0);
        run_drain(0);
        chk_res("mr", 0, 32, 64, 96);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
